// File: rtl/wb_pipe_stage.sv
// MEM->WB pipeline stage with a two-entry (main + skid) buffer, valid/ready
// handshake, synchronous flush, write-enable gating and WB result select.
// The main entry always drives the WB outputs. The skid entry only ever holds
// the instruction that arrived after the one in main.
module wb_pipe_stage #(
  parameter int WIDTH   = 32,
  parameter int REG_AW  = 5,
  parameter int SKID_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              reg_write_m,
  input  logic [1:0]        result_src_m,
  input  logic [WIDTH-1:0]  alu_result_m,
  input  logic [WIDTH-1:0]  read_data_m,
  input  logic [REG_AW-1:0] rd_m,
  input  logic [WIDTH-1:0]  pc_plus4_m,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              reg_write_w,
  output logic [REG_AW-1:0] rd_w,
  output logic [WIDTH-1:0]  result_w,
  output logic [1:0]        occupancy
);

  typedef struct packed {
    logic              rw;
    logic [1:0]        src;
    logic [WIDTH-1:0]  alu;
    logic [WIDTH-1:0]  rdat;
    logic [WIDTH-1:0]  pc4;
    logic [REG_AW-1:0] rd;
  } ent_t;

  // The encoding doubles as the entry count.
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_e;

  state_e state_q, state_d;
  ent_t   main_q, main_d, skid_q, skid_d, in_ent;
  logic   in_ready_q, in_ready_d;
  logic   accept, drain;

  assign in_ent = {reg_write_m, result_src_m, alu_result_m, read_data_m,
                   pc_plus4_m, rd_m};

  assign out_valid = (state_q != EMPTY);
  assign occupancy = state_q;
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;

  // With the skid entry, ready comes straight from a flop so it does not
  // depend on out_ready. Without it, ready must look through to out_ready.
  generate
    if (SKID_EN != 0) begin : g_skid_rdy
      assign in_ready = in_ready_q;
    end else begin : g_main_rdy
      assign in_ready = ~out_valid | out_ready;
    end
  endgenerate

  // Next-state and entry steering. Flush beats accept and drain.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = ONE;
            main_d  = in_ent;
          end
        end
        ONE: begin
          if (accept && !drain) begin
            // Without a skid this cannot happen: ready implies out_ready.
            if (SKID_EN != 0) begin
              state_d = FULL;
              skid_d  = in_ent;
            end
          end else if (drain && !accept) begin
            state_d = EMPTY;
          end else if (accept && drain) begin
            main_d = in_ent;
          end
        end
        FULL: begin
          if (drain) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    in_ready_d = (state_d != FULL);
  end

  // State, registered ready and entry storage. Data holds while invalid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
      main_q     <= '0;
      skid_q     <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
    end
  end

  // WB result select from the main entry. Codes 00 and 11 both pick the ALU.
  always_comb begin
    case (main_q.src)
      2'b01:   result_w = main_q.rdat;
      2'b10:   result_w = main_q.pc4;
      default: result_w = main_q.alu;
    endcase
  end

  assign rd_w        = main_q.rd;
  assign reg_write_w = main_q.rw & out_valid & (|main_q.rd);

endmodule

// File: tb/tb_wb_pipe_stage.sv
// Bench for wb_pipe_stage: a skid build and a no-skid build run side by side.
// The expected behaviour comes from a FIFO-queue reference model. Each build
// has its own source queue, and a source entry is held until it is accepted.
module tb_wb_pipe_stage;

  typedef struct packed {
    logic        rw;
    logic [1:0]  src;
    logic [31:0] alu;
    logic [31:0] rdat;
    logic [31:0] pc4;
    logic [4:0]  rd;
  } ent_t;

  logic clk = 1'b0, rst = 1'b1, flush = 1'b0, out_ready = 1'b0;
  logic iv1 = 1'b0, iv0 = 1'b0;
  ent_t e1 = '0, e0 = '0;
  logic ir1, ov1, rww1, ir0, ov0, rww0;
  logic [4:0]  rdw1, rdw0;
  logic [31:0] res1, res0;
  logic [1:0]  occ1, occ0;
  logic [41:0] ob1, ob0;

  int tests = 0, fails = 0;
  ent_t q1[$], q0[$], src1[$], src0[$];
  logic [31:0] got1[$], got0[$];

  always #5 clk = ~clk;

  wb_pipe_stage #(.WIDTH(32), .REG_AW(5), .SKID_EN(1)) u_skid (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(iv1), .in_ready(ir1),
    .reg_write_m(e1.rw), .result_src_m(e1.src), .alu_result_m(e1.alu),
    .read_data_m(e1.rdat), .rd_m(e1.rd), .pc_plus4_m(e1.pc4),
    .out_valid(ov1), .out_ready(out_ready), .reg_write_w(rww1), .rd_w(rdw1),
    .result_w(res1), .occupancy(occ1));

  wb_pipe_stage #(.WIDTH(32), .REG_AW(5), .SKID_EN(0)) u_noskid (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(iv0), .in_ready(ir0),
    .reg_write_m(e0.rw), .result_src_m(e0.src), .alu_result_m(e0.alu),
    .read_data_m(e0.rdat), .rd_m(e0.rd), .pc_plus4_m(e0.pc4),
    .out_valid(ov0), .out_ready(out_ready), .reg_write_w(rww0), .rd_w(rdw0),
    .result_w(res0), .occupancy(occ0));

  // rd/result only mean something while out_valid is set.
  assign ob1 = {ov1, occ1, ir1, rww1, ov1 ? rdw1 : 5'd0, ov1 ? res1 : 32'd0};
  assign ob0 = {ov0, occ0, ir0, rww0, ov0 ? rdw0 : 5'd0, ov0 ? res0 : 32'd0};

  function automatic logic [31:0] wbval(input ent_t f);
    if (f.src == 2'b01) return f.rdat;
    if (f.src == 2'b10) return f.pc4;
    return f.alu;
  endfunction

  function automatic logic [41:0] exp1();
    ent_t f;
    if (q1.size() == 0) return {1'b0, 2'd0, 1'b1, 1'b0, 5'd0, 32'd0};
    f = q1[0];
    return {1'b1, 2'(q1.size()), q1.size() < 2, f.rw && f.rd != 0, f.rd, wbval(f)};
  endfunction

  function automatic logic [41:0] exp0();
    ent_t f;
    if (q0.size() == 0) return {1'b0, 2'd0, 1'b1, 1'b0, 5'd0, 32'd0};
    f = q0[0];
    return {1'b1, 2'd1, out_ready, f.rw && f.rd != 0, f.rd, wbval(f)};
  endfunction

  function automatic ent_t mk(input logic rw, input logic [1:0] s, input logic [31:0] a,
                              input logic [31:0] r, input logic [31:0] p, input logic [4:0] d);
    ent_t x;
    x.rw = rw; x.src = s; x.alu = a; x.rdat = r; x.pc4 = p; x.rd = d;
    return x;
  endfunction

  function automatic ent_t rnd_ent();
    return mk(1'($urandom), 2'($urandom_range(0, 3)), $urandom, $urandom, $urandom,
              5'($urandom_range(0, 31)));
  endfunction

  // One clock: present source heads, advance the model at the edge, then
  // leave time positioned 2 units after the edge for checks.
  task automatic tick();
    logic a1, a0, d1, d0;
    ent_t x;
    iv1 = src1.size() > 0; e1 = iv1 ? src1[0] : '0;
    iv0 = src0.size() > 0; e0 = iv0 ? src0[0] : '0;
    #1;
    a1 = iv1 && (q1.size() < 2);
    a0 = iv0 && (q0.size() == 0 || out_ready);
    d1 = (q1.size() > 0) && out_ready;
    d0 = (q0.size() > 0) && out_ready;
    if (ov1 && out_ready) got1.push_back(res1);
    if (ov0 && out_ready) got0.push_back(res0);
    @(posedge clk);
    if (a1) x = src1.pop_front();
    if (a0) x = src0.pop_front();
    if (flush) begin
      q1.delete(); q0.delete();
    end else begin
      if (d1) x = q1.pop_front();
      if (a1) q1.push_back(e1);
      if (d0) x = q0.pop_front();
      if (a0) q0.push_back(e0);
    end
    #2;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0; iv1 = 1'b0; iv0 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #2;
    tests++;
    if ({ov1, ir1, occ1, rww1, rdw1, res1} !== {1'b0, 1'b1, 2'd0, 1'b0, 5'd0, 32'd0}) begin
      fails++; $display("FAIL reset skid: got %h want %h", {ov1, ir1, occ1, rww1, rdw1, res1},
                        {1'b0, 1'b1, 2'd0, 1'b0, 5'd0, 32'd0});
    end
    tests++;
    if ({ov0, ir0, occ0, rww0, rdw0, res0} !== {1'b0, 1'b1, 2'd0, 1'b0, 5'd0, 32'd0}) begin
      fails++; $display("FAIL reset noskid: got %h want %h", {ov0, ir0, occ0, rww0, rdw0, res0},
                        {1'b0, 1'b1, 2'd0, 1'b0, 5'd0, 32'd0});
    end
  endtask

  task automatic test_streaming();
    logic [31:0] want;
    out_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      src1.push_back(mk(1'b1, 2'b00, 32'(k * 16), 32'h0, 32'h0, 5'd5));
      src0.push_back(mk(1'b1, 2'b00, 32'(k * 16), 32'h0, 32'h0, 5'd5));
    end
    for (int k = 1; k <= 4; k++) begin
      tick();
      want = (k <= 3) ? 32'(k * 16) : 32'h0;
      tests++;
      if (ob1 !== exp1()) begin fails++; $display("FAIL stream skid: got %h want %h", ob1, exp1()); end
      tests++;
      if (ob0 !== exp0()) begin fails++; $display("FAIL stream noskid: got %h want %h", ob0, exp0()); end
      if (k <= 3) begin
        tests++;
        if (res1 !== want || occ1 !== 2'd1) begin
          fails++; $display("FAIL stream value: got %h/%0d want %h/1", res1, occ1, want);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    got1.delete(); got0.delete();
    for (int k = 0; k < 3; k++) begin
      src1.push_back(mk(1'b1, 2'b00, 32'hA + 32'(k), 32'h0, 32'h0, 5'd1));
      src0.push_back(mk(1'b1, 2'b00, 32'hA + 32'(k), 32'h0, 32'h0, 5'd1));
    end
    repeat (3) begin
      tick();
      tests++;
      if (ob1 !== exp1()) begin fails++; $display("FAIL bp-hold skid: got %h want %h", ob1, exp1()); end
      tests++;
      if (ob0 !== exp0()) begin fails++; $display("FAIL bp-hold noskid: got %h want %h", ob0, exp0()); end
    end
    tests++;
    if (occ1 !== 2'd2 || ir1 !== 1'b0 || res1 !== 32'hA) begin
      fails++; $display("FAIL bp-full: occ %0d rdy %b res %h want 2 0 0000000a", occ1, ir1, res1);
    end
    out_ready = 1'b1;
    repeat (6) begin
      tick();
      tests++;
      if (ob1 !== exp1()) begin fails++; $display("FAIL bp-drain skid: got %h want %h", ob1, exp1()); end
      tests++;
      if (ob0 !== exp0()) begin fails++; $display("FAIL bp-drain noskid: got %h want %h", ob0, exp0()); end
    end
    tests++;
    if (got1.size() != 3 || got1[0] !== 32'hA || got1[1] !== 32'hB || got1[2] !== 32'hC) begin
      fails++; $display("FAIL bp-order skid: got %p want A B C", got1);
    end
    tests++;
    if (got0.size() != 3 || got0[0] !== 32'hA || got0[1] !== 32'hB || got0[2] !== 32'hC) begin
      fails++; $display("FAIL bp-order noskid: got %p want A B C", got0);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    src1.push_back(mk(1'b1, 2'b00, 32'h1, 0, 0, 5'd2)); src1.push_back(mk(1'b1, 2'b00, 32'h2, 0, 0, 5'd2));
    src0.push_back(mk(1'b1, 2'b00, 32'h1, 0, 0, 5'd2)); src0.push_back(mk(1'b1, 2'b00, 32'h2, 0, 0, 5'd2));
    tick(); tick();
    tests++;
    if (occ1 !== 2'd2) begin fails++; $display("FAIL flush-fill: occ got %0d want 2", occ1); end
    src1.push_back(mk(1'b1, 2'b00, 32'hD, 0, 0, 5'd2));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    src1.delete(); src0.delete();
    tests++;
    if ({ov1, occ1, ir1} !== {1'b0, 2'd0, 1'b1}) begin
      fails++; $display("FAIL flush skid: got %b want 0001", {ov1, occ1, ir1});
    end
    tests++;
    if ({ov0, occ0, ir0} !== {1'b0, 2'd0, 1'b1}) begin
      fails++; $display("FAIL flush noskid: got %b want 0001", {ov0, occ0, ir0});
    end
    tick();
    tests++;
    if (ob1 !== exp1() || ov1 !== 1'b0) begin fails++; $display("FAIL flush-after skid: got %h want %h", ob1, exp1()); end
  endtask

  task automatic test_gating();
    out_ready = 1'b1;
    src1.push_back(mk(1'b1, 2'b00, 32'h55, 0, 0, 5'd0));
    src1.push_back(mk(1'b1, 2'b01, 32'h55, 32'hDEADBEEF, 0, 5'd3));
    src1.push_back(mk(1'b1, 2'b10, 32'h55, 0, 32'h104, 5'd7));
    src1.push_back(mk(1'b1, 2'b11, 32'h77, 32'h1, 32'h2, 5'd9));
    src0 = src1;
    tick();
    tests++;
    if (rww1 !== 1'b0 || rww0 !== 1'b0 || ov1 !== 1'b1) begin
      fails++; $display("FAIL gate-x0: rw %b/%b ov %b want 0/0 1", rww1, rww0, ov1);
    end
    tick();
    tests++;
    if (res1 !== 32'hDEADBEEF || rww1 !== 1'b1 || res0 !== 32'hDEADBEEF) begin
      fails++; $display("FAIL gate-mem: res %h/%h rw %b want deadbeef 1", res1, res0, rww1);
    end
    tick();
    tests++;
    if (res1 !== 32'h104 || res0 !== 32'h104) begin
      fails++; $display("FAIL gate-pc4: res %h/%h want 00000104", res1, res0);
    end
    tick();
    tests++;
    if (res1 !== 32'h77 || rdw1 !== 5'd9) begin
      fails++; $display("FAIL gate-src11: res %h rd %0d want 00000077 9", res1, rdw1);
    end
    tick();
    tests++;
    if (rww1 !== 1'b0 || ov1 !== 1'b0) begin
      fails++; $display("FAIL gate-bubble: rw %b ov %b want 0 0", rww1, ov1);
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      src1.push_back(mk(1'b1, 2'b00, 32'h100 + 32'(k), 0, 0, 5'd4));
      src0.push_back(mk(1'b1, 2'b00, 32'h100 + 32'(k), 0, 0, 5'd4));
    end
    tick(); tick();
    @(negedge clk);
    rst = 1'b1;
    #1;
    tests++;
    if ({ov1, ir1, occ1, rww1, rdw1, res1} !== {1'b0, 1'b1, 2'd0, 1'b0, 5'd0, 32'd0}) begin
      fails++; $display("FAIL areset skid: got %h want %h", {ov1, ir1, occ1, rww1, rdw1, res1},
                        {1'b0, 1'b1, 2'd0, 1'b0, 5'd0, 32'd0});
    end
    tests++;
    if ({ov0, ir0, occ0, rww0, rdw0, res0} !== {1'b0, 1'b1, 2'd0, 1'b0, 5'd0, 32'd0}) begin
      fails++; $display("FAIL areset noskid: got %h want %h", {ov0, ir0, occ0, rww0, rdw0, res0},
                        {1'b0, 1'b1, 2'd0, 1'b0, 5'd0, 32'd0});
    end
    q1.delete(); q0.delete(); src1.delete(); src0.delete();
    iv1 = 1'b0; iv0 = 1'b0;
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #2;
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 2) != 0 && src1.size() < 4) src1.push_back(rnd_ent());
      if ($urandom_range(0, 2) != 0 && src0.size() < 4) src0.push_back(rnd_ent());
      tick();
      tests++;
      if (ob1 !== exp1()) begin fails++; $display("FAIL random skid cyc %0d: got %h want %h", n, ob1, exp1()); end
      tests++;
      if (ob0 !== exp0()) begin fails++; $display("FAIL random noskid cyc %0d: got %h want %h", n, ob0, exp0()); end
    end
    flush = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_gating();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
